// File: rtl/pipe_stall_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stall_ctrl_pkg
// Description : Shared definitions for the pipeline stall/flush sequencer.
//               Holds the sequencer FSM state encodings and the default
//               mul/div EX occupancy, which the EX mul/div unit also uses.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_stall_ctrl_pkg;

  // Sequencer FSM state encodings
  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_MD_WAIT = 2'd1;
  localparam logic [1:0] ST_FLUSH   = 2'd2;

  // EX occupancy of multi-cycle ops, shared with the mul/div datapath
  localparam int MUL_CYCLES_DEF = 4;
  localparam int DIV_CYCLES_DEF = 33;
  localparam int CNT_W_DEF      = 6;

endpackage
`default_nettype wire

// File: rtl/pipe_stall_ctrl_md_cycle_counter.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stall_ctrl_md_cycle_counter
// Description : Down-counter that tracks the remaining mul/div freeze cycles.
//               Priority: clear > load > decrement. 'last' flags the final
//               frozen cycle (count reads 1).
// Ports       : clk, resetn   - clock, async active-low reset
//               clr           - clear to zero (exception abort)
//               load/load_val - load remaining-cycle count
//               dec           - decrement (saturates at zero)
//               last          - count equals 1
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stall_ctrl_md_cycle_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             last
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule
`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stall_ctrl
// Description : Central stall/flush sequencer for the 5-stage pipeline.
//               Resolves load-use and mfc0-after-mtc0 hazards with bubbles,
//               freezes the pipe during multi-cycle mul/div, and sequences
//               exception/eret flushes (which abort everything else).
// Ports       : clk, resetn                 - clock, async active-low reset
//               id_rs/id_rt/id_use_*/id_mfc0 - ID-stage operand info
//               ex_is_load/ex_wreg/ex_mtc0   - EX-stage producer info
//               mem_mtc0                     - MEM holds an mtc0
//               ex_md_start/ex_md_is_div     - new mul/div entered EX
//               cp0_ex/eret                  - exception / eret commit
//               pc_stall, if_id_stall, id_ex_stall     - register holds
//               if_id_flush, id_ex_flush, ex_mem_flush - register clears
//               pc_redirect                  - PC takes vector / EPC
//               md_busy                      - registered freeze indicator
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       id_mfc0,
  input  logic       ex_is_load,
  input  logic [4:0] ex_wreg,
  input  logic       ex_mtc0,
  input  logic       mem_mtc0,
  input  logic       ex_md_start,
  input  logic       ex_md_is_div,
  input  logic       cp0_ex,
  input  logic       eret,
  output logic       pc_stall,
  output logic       if_id_stall,
  output logic       if_id_flush,
  output logic       id_ex_stall,
  output logic       id_ex_flush,
  output logic       ex_mem_flush,
  output logic       pc_redirect,
  output logic       md_busy
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             md_busy_q;
  logic             exc;
  logic             lu_haz;
  logic             c0_haz;
  logic [CNT_W-1:0] md_load_val;
  logic             md_go;
  logic             md_dec;
  logic             md_last;

  // Decoded controls before the reset gate
  logic pc_stall_d, if_id_stall_d, if_id_flush_d, id_ex_stall_d;
  logic id_ex_flush_d, ex_mem_flush_d, pc_redirect_d;

  assign exc    = cp0_ex | eret;
  assign lu_haz = ex_is_load & (ex_wreg != 5'd0) &
                  ((id_use_rs & (id_rs == ex_wreg)) | (id_use_rt & (id_rt == ex_wreg)));
  assign c0_haz = id_mfc0 & (ex_mtc0 | mem_mtc0);

  assign md_load_val = ex_md_is_div ? DIV_LOAD : MUL_LOAD;
  // A 1-cycle op needs no freeze, so a zero reload never enters MD_WAIT
  assign md_go  = (state == ST_RUN) & ex_md_start & ~exc & (md_load_val != '0);
  assign md_dec = (state == ST_MD_WAIT) & ~exc;

  pipe_stall_ctrl_md_cycle_counter #(
    .CNT_W (CNT_W)
  ) u_md_cnt (
    .clk      (clk),
    .resetn   (resetn),
    .clr      (exc),
    .load     (md_go),
    .load_val (md_load_val),
    .dec      (md_dec),
    .last     (md_last)
  );

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_RUN;
      md_busy_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      md_busy_q <= (state_nxt == ST_MD_WAIT);
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = ST_RUN;
    if (exc) begin
      state_nxt = ST_FLUSH;
    end else begin
      case (state)
        ST_RUN:     state_nxt = md_go ? ST_MD_WAIT : ST_RUN;
        ST_MD_WAIT: state_nxt = md_last ? ST_RUN : ST_MD_WAIT;
        ST_FLUSH:   state_nxt = ST_RUN;
        default:    state_nxt = ST_RUN;
      endcase
    end
  end

  // Output decode: exception > freeze > hazard bubble
  always_comb begin
    pc_stall_d     = 1'b0;
    if_id_stall_d  = 1'b0;
    if_id_flush_d  = 1'b0;
    id_ex_stall_d  = 1'b0;
    id_ex_flush_d  = 1'b0;
    ex_mem_flush_d = 1'b0;
    pc_redirect_d  = 1'b0;
    if (exc) begin
      pc_redirect_d  = 1'b1;
      if_id_flush_d  = 1'b1;
      id_ex_flush_d  = 1'b1;
      ex_mem_flush_d = 1'b1;
    end else if (state == ST_FLUSH) begin
      // Squash the fetch that was issued from the pre-redirect PC
      if_id_flush_d = 1'b1;
    end else if (state == ST_MD_WAIT) begin
      pc_stall_d     = 1'b1;
      if_id_stall_d  = 1'b1;
      id_ex_stall_d  = 1'b1;
      ex_mem_flush_d = 1'b1;
    end else if (lu_haz | c0_haz) begin
      pc_stall_d    = 1'b1;
      if_id_stall_d = 1'b1;
      id_ex_flush_d = 1'b1;
    end
  end

  // All controls read as zero while reset is held
  assign pc_stall     = resetn & pc_stall_d;
  assign if_id_stall  = resetn & if_id_stall_d;
  assign if_id_flush  = resetn & if_id_flush_d;
  assign id_ex_stall  = resetn & id_ex_stall_d;
  assign id_ex_flush  = resetn & id_ex_flush_d;
  assign ex_mem_flush = resetn & ex_mem_flush_d;
  assign pc_redirect  = resetn & pc_redirect_d;
  assign md_busy      = resetn & md_busy_q;

endmodule
`default_nettype wire
